// File: rtl/ce_rate_meter_pkg.sv
// ce_rate_meter_pkg: shared FSM state encoding and tick-counter sizing for the rate meter.
package ce_rate_meter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    function automatic int tick_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ce_rate_meter_if.sv
// ce_rate_meter_if: timebase/event inputs and the valid/ack result port of the rate meter.
interface ce_rate_meter_if #(parameter int COUNTER_WIDTH = 32);
    logic                     ce;
    logic                     enable;
    logic                     event_in;
    logic                     rate_ack;
    logic [COUNTER_WIDTH-1:0] rate;
    logic                     rate_valid;
    logic                     overflow;
    logic                     missed;

    modport master (output ce, enable, event_in, rate_ack,
                    input  rate, rate_valid, overflow, missed);
    modport slave  (input  ce, enable, event_in, rate_ack,
                    output rate, rate_valid, overflow, missed);
endinterface

// File: rtl/ce_rate_meter_edge_sync.sv
// event_edge_sync: synchronises an asynchronous input and emits a one-cycle rising-edge pulse.
module event_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d;
endmodule

// File: rtl/ce_rate_meter.sv
// ce_rate_meter: counts EVENT_IN rising edges over GATE_TICKS CE ticks and offers each
// window result through a valid/ack register with overflow and missed-result flags.
module ce_rate_meter
    import ce_rate_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int GATE_TICKS    = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk,
    input  logic            rst,
    ce_rate_meter_if.slave  bus
);
    localparam int                       TW   = tick_width(GATE_TICKS);
    localparam logic [COUNTER_WIDTH-1:0] MAX  = '1;
    localparam logic [TW-1:0]            LAST = TW'(GATE_TICKS - 1);

    state_t                   r_state;
    logic [COUNTER_WIDTH-1:0] r_acc;
    logic [COUNTER_WIDTH-1:0] r_rate;
    logic [TW-1:0]            r_tick;
    logic                     r_sat;
    logic                     r_valid;
    logic                     r_ovf;
    logic                     r_missed;
    logic                     w_edge;
    logic                     w_full;
    logic                     w_close;
    logic                     w_ack;

    event_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.event_in),
        .o_edge  (w_edge)
    );

    assign w_full  = r_acc == MAX;
    assign w_close = bus.enable && r_state == COUNT && bus.ce && r_tick == LAST;
    assign w_ack   = bus.rate_ack && r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_rate   <= '0;
            r_tick   <= '0;
            r_sat    <= 1'b0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            if (!bus.enable)
                r_state <= IDLE;
            else case (r_state)
                IDLE: r_state <= ARM;
                ARM: if (bus.ce) begin
                    r_state <= COUNT;
                    r_acc   <= '0;
                    r_tick  <= '0;
                    r_sat   <= 1'b0;
                end
                COUNT: if (w_close) begin
                    r_acc  <= '0;
                    r_tick <= '0;
                    r_sat  <= 1'b0;
                end else begin
                    if (w_edge && w_full) r_sat <= 1'b1;
                    if (w_edge && !w_full) r_acc <= r_acc + COUNTER_WIDTH'(1);
                    if (bus.ce) r_tick <= r_tick + TW'(1);
                end
                default: r_state <= IDLE;
            endcase
            // the closing-cycle edge belongs to the window being latched
            if (w_close) begin
                r_rate <= r_acc + COUNTER_WIDTH'(w_edge && !w_full);
                r_ovf  <= r_sat || (w_edge && w_full);
            end
            if (w_close || w_ack) r_valid <= w_close;
            if (w_ack) r_missed <= 1'b0;
            else if (w_close && r_valid) r_missed <= 1'b1;
        end
    end

    assign bus.rate       = r_rate;
    assign bus.rate_valid = r_valid;
    assign bus.overflow   = r_ovf;
    assign bus.missed     = r_missed;
endmodule

// File: tb/tb_ce_rate_meter.sv
// tb_ce_rate_meter: directed and random stimulus against a behavioural window-count model,
// with expected outputs queued per cycle and compared by an independent monitor.
module tb_ce_rate_meter;
    localparam int CW     = 8;
    localparam int G      = 4;
    localparam int S      = 2;
    localparam int CE_DIV = 200;
    localparam int MAXV   = (1 << CW) - 1;

    typedef struct {
        int rate;
        int valid;
        int ovf;
        int missed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ce_rate_meter_if #(.COUNTER_WIDTH(CW)) bus ();

    ce_rate_meter #(.COUNTER_WIDTH(CW), .GATE_TICKS(G), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    int         cnt = 0;
    logic       en  = 1'b0;
    int         m_mode, m_acc, m_tick, m_sat;
    int         m_rate, m_valid, m_ovf, m_missed;
    logic [S:0] hist;
    bit         m_latched;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // window-level reference: mode 0 idle, 1 waiting for first CE, 2 measuring
    task automatic model(input bit ce, input bit ev, input bit ack, input bit r);
        int e;
        bit l, a;
        m_latched = 0;
        if (r) begin
            m_mode = 0; m_acc = 0; m_tick = 0; m_sat = 0;
            m_rate = 0; m_valid = 0; m_ovf = 0; m_missed = 0;
            hist = '0;
            return;
        end
        e = (hist[S-1] && !hist[S]) ? 1 : 0;
        l = 0;
        a = ack && m_valid != 0;
        if (!en) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1) begin
            if (ce) begin m_mode = 2; m_acc = 0; m_tick = 0; m_sat = 0; end
        end else if (ce && m_tick == G - 1) begin
            l = 1;
            m_rate = (m_acc + e > MAXV) ? MAXV : m_acc + e;
            m_ovf = (m_sat != 0 || m_acc + e > MAXV) ? 1 : 0;
            m_acc = 0; m_tick = 0; m_sat = 0;
        end else begin
            if (e != 0) begin
                if (m_acc == MAXV) m_sat = 1;
                else m_acc++;
            end
            if (ce) m_tick++;
        end
        if (a) m_missed = 0;
        else if (l && m_valid != 0) m_missed = 1;
        if (l) m_valid = 1;
        else if (a) m_valid = 0;
        m_latched = l;
        hist = {hist[S-1:0], ev};
    endtask

    task automatic step(input bit ev, input bit ack);
        bit ce;
        exp_t x;
        ce = (cnt == CE_DIV - 1);
        bus.ce = ce;
        bus.enable = en;
        bus.event_in = ev;
        bus.rate_ack = ack;
        @(posedge clk);
        model(ce, ev, ack, rst);
        cnt = (cnt == CE_DIV - 1) ? 0 : cnt + 1;
        x.rate = m_rate; x.valid = m_valid; x.ovf = m_ovf; x.missed = m_missed;
        exp_q.push_back(x);
        #1;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            repeat (hi) step(1'b1, 1'b0);
            repeat (lo) step(1'b0, 1'b0);
        end
    endtask

    task automatic wait_close(input bit ack_on_close);
        bit done = 0;
        for (int i = 0; i < 4 * G * CE_DIV && !done; i++) begin
            step(1'b0, ack_on_close && m_mode == 2 && m_tick == G - 1 && cnt == CE_DIV - 1);
            done = m_latched;
        end
        if (!done) chk("window_close_timeout", 0, 1);
    endtask

    task automatic wait_window_start();
        bit done = 0;
        for (int i = 0; i < 2 * CE_DIV && !done; i++) begin
            step(1'b0, 1'b0);
            done = (m_mode == 2 && m_tick == 0);
        end
        if (!done) chk("window_start_timeout", 0, 1);
    endtask

    task automatic chk_out(input string name, input int rate, input int valid, input int ovf, input int missed);
        chk({name, "_rate"}, int'(bus.rate), rate);
        chk({name, "_valid"}, int'(bus.rate_valid), valid);
        chk({name, "_ovf"}, int'(bus.overflow), ovf);
        chk({name, "_missed"}, int'(bus.missed), missed);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("sb_rate", int'(bus.rate), x.rate);
                chk("sb_valid", int'(bus.rate_valid), x.valid);
                chk("sb_ovf", int'(bus.overflow), x.ovf);
                chk("sb_missed", int'(bus.missed), x.missed);
            end
        end
    end

    initial begin : driver
        bit done;
        hist = '0;
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b0);
        chk_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        en = 1'b1;

        wait_window_start();
        repeat (5) step(1'b0, 1'b0);
        pulses(25, 2, 2);
        wait_close(1'b0);
        chk_out("t1", 25, 1, 0, 0);

        step(1'b0, 1'b1);
        done = 0;
        for (int i = 0; i < 2 * G * CE_DIV && !done; i++) begin
            done = (m_mode == 2 && m_tick == G - 1 && cnt == CE_DIV - 3);
            if (!done) step(1'b0, 1'b0);
        end
        if (!done) chk("t2_align_timeout", 0, 1);
        repeat (3) step(1'b1, 1'b0);
        chk("t2_latched", int'(m_latched), 1);
        chk_out("t2_close", 1, 1, 0, 0);
        repeat (10) step(1'b1, 1'b1);
        wait_close(1'b0);
        chk_out("t2_next", 0, 1, 0, 0);

        step(1'b0, 1'b1);
        pulses(300, 1, 1);
        wait_close(1'b0);
        chk_out("t3_sat", MAXV, 1, 1, 0);
        pulses(3, 2, 2);
        wait_close(1'b0);
        chk_out("t3_after", 3, 1, 0, 1);
        wait_close(1'b1);
        chk_out("t4_ack_latch", 0, 1, 0, 0);

        repeat (3) step(1'b0, 1'b0);
        pulses(7, 2, 2);
        en = 1'b0;
        repeat (20) step(1'b0, 1'b0);
        chk_out("t5_disabled", 0, 1, 0, 0);
        en = 1'b1;
        pulses(10, 2, 2);
        wait_close(1'b0);
        wait_close(1'b0);

        repeat (30) step(1'b1, 1'b0);
        pulses(5, 1, 1);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk_out("t6_reset", 0, 0, 0, 0);
        pulses(4, 2, 3);
        wait_close(1'b0);
        wait_close(1'b0);

        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 599) == 0) en = ~en;
            if (!en && $urandom_range(0, 49) == 0) en = 1'b1;
            rst = ($urandom_range(0, 2999) == 0);
            step(1'(($urandom_range(0, 2) == 0) ? ~hist[0] : hist[0]), 1'($urandom_range(0, 15) == 0));
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
